mlab_scfifo_par: RTL and testbench
==================================

MLAB_SCFIFO_PAR -- requirements
Module: mlab_scfifo_par

Interface
REQ-001 SHALL have parameter LABS_WIDE, default 1: data width in 20-bit LAB slices; data width W = LABS_WIDE*20.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: depth D = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter AF_THR, default D-4: almost_full threshold in words.
REQ-004 SHALL have parameter AE_THR, default 4: almost_empty threshold in words.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port srst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port wrreq, input, 1 bit: write request.
REQ-008 SHALL have port wrdata, input, W bits: write data.
REQ-009 SHALL have port rdreq, input, 1 bit: read request.
REQ-010 SHALL have port rddata, output, W bits: read data, meaningful only when rdvalid=1.
REQ-011 SHALL have port rdvalid, output, 1 bit: rddata holds a popped word.
REQ-012 SHALL have ports full and empty, outputs, 1 bit each: occupancy flags.
REQ-013 SHALL have ports almost_full and almost_empty, outputs, 1 bit each: threshold flags.
REQ-014 SHALL have port used, output, ADDR_WIDTH+1 bits: current word count, 0..D.
REQ-015 SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.
REQ-016 SHALL have port err_inject, input, 1 bit: test-only input that corrupts the stored parity of the word written in the same cycle.
REQ-017 SHALL have port parity_err, output, 1 bit: parity mismatch on the current rddata.

Function
REQ-018 SHALL accept a write when wrreq=1 and full=0 at the clock edge; the word is stored at the write pointer, and the pointer wraps modulo D.
REQ-019 SHALL accept a read when rdreq=1 and empty=0; the read pointer advances modulo D.
REQ-020 SHALL evaluate full and empty on pre-edge state, so a write at full is refused even if a read is accepted in the same cycle, and a read at empty is refused even if a write is accepted in the same cycle.
REQ-021 SHALL update used on each edge: +1 for an accepted write only, -1 for an accepted read only, unchanged for both or neither.
REQ-022 SHALL register full=(used==D), empty=(used==0), almost_full=(used>=AF_THR) and almost_empty=(used<=AE_THR), all consistent with used in the same cycle.
REQ-023 SHALL have read latency 2: an accepted read at edge N gives rdvalid=1 and the popped word on rddata after edge N+2, with rdvalid high for exactly one cycle per accepted read.
REQ-024 SHALL support back-to-back reads at one word per cycle with FIFO order preserved, including across pointer wrap.
REQ-025 SHALL set overflow on a refused write (wrreq=1 while full=1) and underflow on a refused read (rdreq=1 while empty=1); both flags hold until reset.
REQ-026 SHALL hold rddata at its last value when rdvalid=0.
REQ-027 SHALL use memory that is readable the cycle after a write (MLAB-friendly: registered read address plus output register), with no read-during-write hazard visible at the ports.

Reset
REQ-028 SHALL, when srst_n=0 at a rising edge, clear both pointers, used=0, empty=1, almost_empty=1, full=0, almost_full=0, rdvalid=0, rddata=0, overflow=0, underflow=0 and parity_err=0.
REQ-029 SHALL discard in-flight reads on reset: rdvalid stays 0 for the two cycles after reset even if reads were accepted before it.
REQ-030 SHALL ignore wrreq and rdreq while srst_n=0; memory contents are not cleared.

Configuration
REQ-031 SHALL, with MLAB_SCFIFO_PARITY_EN defined, store one even-parity bit per 20-bit slice (LABS_WIDE bits, inverted when err_inject=1), recheck it at the output, and assert parity_err alongside rdvalid for that word when any slice mismatches.
REQ-032 SHALL, without MLAB_SCFIFO_PARITY_EN, store no parity bits, ignore err_inject, and tie parity_err to 0.

Verification
REQ-033 SHALL cover this case: LABS_WIDE=1, ADDR_WIDTH=5, write 32 words 1..32 with no reads -> full=1 and used=32 after the 32nd write, almost_full=1 from used=28; a 33rd wrreq leaves used=32 and sets overflow=1.
REQ-034 SHALL cover this case: from full, hold rdreq for 32 cycles -> rdvalid on 32 consecutive cycles starting 2 cycles after the first read, data 1..32 in order, then empty=1; one further rdreq sets underflow=1.
REQ-035 SHALL cover this case: used=10, wrreq=1 and rdreq=1 together for 100 cycles -> used stays 10 and the output sequence stays incrementing across pointer wrap.
REQ-036 SHALL cover this case: empty, wrreq=1 and rdreq=1 in the same cycle -> write accepted, read refused, used=1 and underflow=1.
REQ-037 SHALL cover this case: with MLAB_SCFIFO_PARITY_EN, write 0x00005 with err_inject=1 then 0x00006 with err_inject=0 and read both -> parity_err=1 with the first rdvalid only; without the macro, parity_err stays 0.
REQ-038 SHALL cover this case: srst_n=0 for one cycle while 2 reads are in flight and used=6 -> no rdvalid afterwards, used=0, empty=1, overflow=0 and underflow=0.

Source files
------------

// File: rtl/mlab_scfifo_par.sv
// mlab_scfifo_par: single-clock FIFO on MLAB-style memory with a 2-cycle read latency.
// Optional per-20-bit-slice even parity, enabled by defining MLAB_SCFIFO_PARITY_EN.
module mlab_scfifo_par #(
   parameter int LABS_WIDE  = 1,
   parameter int ADDR_WIDTH = 5,
   parameter int AF_THR     = (1 << ADDR_WIDTH) - 4,
   parameter int AE_THR     = 4
) (
   input  logic                      clk,
   input  logic                      srst_n,
   input  logic                      wrreq,
   input  logic [LABS_WIDE*20-1:0]   wrdata,
   input  logic                      rdreq,
   output logic [LABS_WIDE*20-1:0]   rddata,
   output logic                      rdvalid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [ADDR_WIDTH:0]       used,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      err_inject,
   output logic                      parity_err
);
   localparam int W = LABS_WIDE * 20;
   localparam int D = 1 << ADDR_WIDTH;
`ifdef MLAB_SCFIFO_PARITY_EN
   localparam int MW = W + LABS_WIDE;
`else
   localparam int MW = W;
`endif
   localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(D);
   localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_THR);
   localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_THR);

   logic [MW-1:0]          r_mem [0:D-1];
   logic [MW-1:0]          r_mem_q;
   logic [MW-1:0]          w_wr_word;
   logic [ADDR_WIDTH-1:0]  r_wr_ptr;
   logic [ADDR_WIDTH-1:0]  r_rd_ptr;
   logic [ADDR_WIDTH-1:0]  r_rd_addr;
   logic [ADDR_WIDTH:0]    r_used;
   logic [ADDR_WIDTH:0]    w_used_next;
   logic                   r_full;
   logic                   r_empty;
   logic                   r_afull;
   logic                   r_aempty;
   logic                   r_ovf;
   logic                   r_udf;
   logic                   r_rd_v1;
   logic                   r_rd_v2;
   logic                   r_rdvalid;
   logic [W-1:0]           r_rddata;
   logic                   w_wr_acc;
   logic                   w_rd_acc;

   // Acceptance uses the registered (pre-edge) flags only.
   assign w_wr_acc = wrreq & ~r_full;
   assign w_rd_acc = rdreq & ~r_empty;

   always_comb begin
      w_used_next = r_used;
      if (w_wr_acc && !w_rd_acc) begin
         w_used_next = r_used + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_used_next = r_used - 1'b1;
      end
   end

`ifdef MLAB_SCFIFO_PARITY_EN
   logic [LABS_WIDE-1:0] w_wr_par;
   logic [LABS_WIDE-1:0] w_rd_mis;
   logic                 r_parity_err;

   generate
      for (genvar gi = 0; gi < LABS_WIDE; gi++) begin : g_par
         assign w_wr_par[gi] = (^wrdata[gi*20 +: 20]) ^ err_inject;
         assign w_rd_mis[gi] = (^r_mem_q[gi*20 +: 20]) ^ r_mem_q[W+gi];
      end
   endgenerate

   assign w_wr_word  = {w_wr_par, wrdata};
   assign parity_err = r_parity_err;

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_parity_err <= 1'b0;
      end else begin
         r_parity_err <= r_rd_v2 & (|w_rd_mis);
      end
   end
`else
   logic w_unused_err_inject;
   assign w_unused_err_inject = err_inject;
   assign w_wr_word  = wrdata;
   assign parity_err = 1'b0;
`endif

   // Storage is never reset; registered address plus registered data maps onto MLAB.
   always_ff @(posedge clk) begin
      if (w_wr_acc && srst_n) begin
         r_mem[r_wr_ptr] <= w_wr_word;
      end
      r_mem_q <= r_mem[r_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_addr <= '0;
         r_used    <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_afull   <= 1'b0;
         r_aempty  <= 1'b1;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         r_rd_v1   <= 1'b0;
         r_rd_v2   <= 1'b0;
         r_rdvalid <= 1'b0;
         r_rddata  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_rd_addr <= r_rd_ptr;
         r_used    <= w_used_next;
         r_full    <= (w_used_next == C_DEPTH);
         r_empty   <= (w_used_next == '0);
         r_afull   <= (w_used_next >= C_AF);
         r_aempty  <= (w_used_next <= C_AE);
         r_ovf     <= r_ovf | (wrreq & r_full);
         r_udf     <= r_udf | (rdreq & r_empty);
         // Valid tracks the address -> memory register -> output register pipeline.
         r_rd_v1   <= w_rd_acc;
         r_rd_v2   <= r_rd_v1;
         r_rdvalid <= r_rd_v2;
         if (r_rd_v2) begin
            r_rddata <= r_mem_q[W-1:0];
         end
      end
   end

   assign rddata       = r_rddata;
   assign rdvalid      = r_rdvalid;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign used         = r_used;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_mlab_scfifo_par.sv
// Directed bench for mlab_scfifo_par (LABS_WIDE=1, ADDR_WIDTH=5): vector table plus corner sequences.
module tb_mlab_scfifo_par;
   logic        clk = 1'b0;
   logic        srst_n;
   logic        wrreq;
   logic [19:0] wrdata;
   logic        rdreq;
   logic [19:0] rddata;
   logic        rdvalid;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic        almost_empty;
   logic [5:0]  used;
   logic        overflow;
   logic        underflow;
   logic        err_inject;
   logic        parity_err;

`ifdef MLAB_SCFIFO_PARITY_EN
   localparam logic EXP_PERR = 1'b1;
`else
   localparam logic EXP_PERR = 1'b0;
`endif

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        wr;
      logic [19:0] din;
      logic        rd;
      int          exp_used;
      logic        exp_empty;
      logic        exp_rdvalid;
      logic [19:0] exp_rddata;
   } vec_t;

   vec_t vecs [10];

   mlab_scfifo_par #(.LABS_WIDE(1), .ADDR_WIDTH(5)) dut (
      .clk(clk), .srst_n(srst_n), .wrreq(wrreq), .wrdata(wrdata), .rdreq(rdreq),
      .rddata(rddata), .rdvalid(rdvalid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .used(used),
      .overflow(overflow), .underflow(underflow), .err_inject(err_inject),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [3:0]  exp_flags;
      logic [19:0] exp_d;
      logic        exp_v;

      vecs[0] = '{1'b1, 20'hA1, 1'b0, 1, 1'b0, 1'b0, 20'h0};
      vecs[1] = '{1'b1, 20'hA2, 1'b0, 2, 1'b0, 1'b0, 20'h0};
      vecs[2] = '{1'b1, 20'hA3, 1'b1, 2, 1'b0, 1'b0, 20'h0};
      vecs[3] = '{1'b0, 20'h0,  1'b0, 2, 1'b0, 1'b0, 20'h0};
      vecs[4] = '{1'b0, 20'h0,  1'b0, 2, 1'b0, 1'b1, 20'hA1};
      vecs[5] = '{1'b0, 20'h0,  1'b1, 1, 1'b0, 1'b0, 20'hA1};
      vecs[6] = '{1'b0, 20'h0,  1'b1, 0, 1'b1, 1'b0, 20'hA1};
      vecs[7] = '{1'b0, 20'h0,  1'b0, 0, 1'b1, 1'b1, 20'hA2};
      vecs[8] = '{1'b0, 20'h0,  1'b0, 0, 1'b1, 1'b1, 20'hA3};
      vecs[9] = '{1'b0, 20'h0,  1'b0, 0, 1'b1, 1'b0, 20'hA3};

      srst_n = 1'b0; wrreq = 1'b0; rdreq = 1'b0; wrdata = '0; err_inject = 1'b0;
      #2;
      step();
      step();
      srst_n = 1'b1;
      chk("rst_used", 32'(used), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_aempty", 32'(almost_empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_afull", 32'(almost_full), 0);
      chk("rst_rdvalid", 32'(rdvalid), 0);
      chk("rst_rddata", 32'(rddata), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_udf", 32'(underflow), 0);
      chk("rst_perr", 32'(parity_err), 0);

      // Vector table: basic writes, simultaneous write/read, latency and hold.
      for (int i = 0; i < 10; i++) begin
         wrreq = vecs[i].wr; wrdata = vecs[i].din; rdreq = vecs[i].rd;
         step();
         chk($sformatf("vec%0d_used", i), 32'(used), 32'(vecs[i].exp_used));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
         chk($sformatf("vec%0d_rdvalid", i), 32'(rdvalid), 32'(vecs[i].exp_rdvalid));
         chk($sformatf("vec%0d_rddata", i), 32'(rddata), 32'(vecs[i].exp_rddata));
      end
      wrreq = 1'b0; rdreq = 1'b0;

      // Write and read together while empty: write taken, read refused.
      wrreq = 1'b1; rdreq = 1'b1; wrdata = 20'h77;
      step();
      wrreq = 1'b0; rdreq = 1'b0;
      chk("wr_rd_empty_used", 32'(used), 1);
      chk("wr_rd_empty_udf", 32'(underflow), 1);
      chk("wr_rd_empty_empty", 32'(empty), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("wr_rd_empty_norv%0d", i), 32'(rdvalid), 0);
      end

      // Reset ignores requests and clears state.
      srst_n = 1'b0; wrreq = 1'b1; rdreq = 1'b1; wrdata = 20'h99;
      step();
      srst_n = 1'b1; wrreq = 1'b0; rdreq = 1'b0;
      chk("rst2_used", 32'(used), 0);
      chk("rst2_udf", 32'(underflow), 0);
      chk("rst2_empty", 32'(empty), 1);
      chk("rst2_rddata", 32'(rddata), 0);

      // Fill to full with 1..32.
      for (int k = 1; k <= 32; k++) begin
         wrreq = 1'b1; wrdata = 20'(k);
         step();
         chk($sformatf("fill%0d_used", k), 32'(used), 32'(k));
         exp_flags = {(k == 32), (k >= 28), (k <= 4), 1'b0};
         chk($sformatf("fill%0d_flags", k), 32'({full, almost_full, almost_empty, empty}),
             32'(exp_flags));
      end
      wrdata = 20'd33;
      step();
      wrreq = 1'b0;
      chk("ovf_used", 32'(used), 32);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_full", 32'(full), 1);

      // Drain from full with rdreq held, then one refused read.
      for (int s = 1; s <= 35; s++) begin
         rdreq = (s <= 32 || s == 35);
         step();
         exp_v = (s >= 3 && s <= 34);
         exp_d = (s < 3) ? 20'd0 : ((s <= 34) ? 20'(s - 2) : 20'd32);
         chk($sformatf("drain%0d_rdvalid", s), 32'(rdvalid), 32'(exp_v));
         chk($sformatf("drain%0d_rddata", s), 32'(rddata), 32'(exp_d));
         chk($sformatf("drain%0d_used", s), 32'(used), (s <= 32) ? 32'(32 - s) : 0);
         chk($sformatf("drain%0d_empty", s), 32'(empty), 32'(s >= 32));
         chk($sformatf("drain%0d_udf", s), 32'(underflow), 32'(s == 35));
      end
      rdreq = 1'b0;

      // Reset with reads in flight discards them.
      for (int k = 0; k < 8; k++) begin
         wrreq = 1'b1; wrdata = 20'(101 + k);
         step();
      end
      wrreq = 1'b0; rdreq = 1'b1;
      step();
      step();
      chk("inflight_used", 32'(used), 6);
      srst_n = 1'b0; wrreq = 1'b1; rdreq = 1'b1;
      step();
      srst_n = 1'b1; wrreq = 1'b0; rdreq = 1'b0;
      chk("inflight_rst_used", 32'(used), 0);
      chk("inflight_rst_empty", 32'(empty), 1);
      chk("inflight_rst_ovf", 32'(overflow), 0);
      chk("inflight_rst_udf", 32'(underflow), 0);
      chk("inflight_rst_rdvalid", 32'(rdvalid), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("inflight_norv%0d", i), 32'(rdvalid), 0);
      end

      // Steady state at used=10 with simultaneous write/read across pointer wrap.
      for (int k = 1; k <= 10; k++) begin
         wrreq = 1'b1; wrdata = 20'(k);
         step();
      end
      chk("steady_pre_used", 32'(used), 10);
      for (int s = 1; s <= 102; s++) begin
         wrreq = (s <= 100); rdreq = (s <= 100); wrdata = 20'(10 + s);
         step();
         if (s <= 100) begin
            chk($sformatf("steady%0d_used", s), 32'(used), 10);
         end
         chk($sformatf("steady%0d_rdvalid", s), 32'(rdvalid), 32'(s >= 3));
         if (s >= 3) begin
            chk($sformatf("steady%0d_rddata", s), 32'(rddata), 32'(s - 2));
         end
      end
      wrreq = 1'b0; rdreq = 1'b0;

      // Parity error injection on the first of two words.
      srst_n = 1'b0;
      step();
      srst_n = 1'b1;
      wrreq = 1'b1; wrdata = 20'h00005; err_inject = 1'b1;
      step();
      wrdata = 20'h00006; err_inject = 1'b0;
      step();
      wrreq = 1'b0; rdreq = 1'b1;
      step();
      step();
      rdreq = 1'b0;
      step();
      chk("par0_rdvalid", 32'(rdvalid), 1);
      chk("par0_rddata", 32'(rddata), 32'h5);
      chk("par0_perr", 32'(parity_err), 32'(EXP_PERR));
      step();
      chk("par1_rdvalid", 32'(rdvalid), 1);
      chk("par1_rddata", 32'(rddata), 32'h6);
      chk("par1_perr", 32'(parity_err), 0);
      step();
      chk("par2_rdvalid", 32'(rdvalid), 0);
      chk("par2_perr", 32'(parity_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
